dbus_periph_bridge: RTL and testbench

- Parametrised data-bus-to-peripheral bridge: generalised successor of the fixed 7-way dbus select/read-mux.
- Accepts one LSU-side data request, decodes it against a parameterised base/mask table for N slaves, drives a one-hot select plus shared request bus, and collects the selected slave's ack/rdata.
- Adds behaviour the fixed version lacks: registered request capture, unmapped-address error response, and a per-transaction timeout with error response.
- Sits between the core's data bus and the peripheral set (uart, clint, plic, spi, boot mem, ...).

---
 rtl/dbus_periph_bridge.sv | 183 ++++++++++++++++++
 tb/tb_dbus_periph_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_periph_bridge.sv
// dbus_periph_bridge: data-bus to peripheral bridge with N decoded slaves.
// Registered request capture, unmapped-address and timeout error acks.
//
// Optional macro DBUS_BRIDGE_ERR_CAPTURE_EN adds error capture outputs:
//   err_addr_o, err_cause_o (0 unmapped, 1 timeout), err_cnt_o (saturating).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m_req_i .. m_be_i   master request (held until m_ack_o)
//   m_ack_o/err/rdata   one-cycle completion with error flag and read data
//   s_sel_o             one-hot slave select
//   s_we_o .. s_be_o    registered request bus shared by all slaves
//   s_ack_i, s_rdata_i  per-slave ack and read data
//   busy_o              transaction in flight
module dbus_periph_bridge #(
   parameter int NUM_SLAVES = 7,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = '0,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         m_req_i,
   input  logic                         m_we_i,
   input  logic [ADDR_W-1:0]            m_addr_i,
   input  logic [DATA_W-1:0]            m_wdata_i,
   input  logic [DATA_W/8-1:0]          m_be_i,
   output logic                         m_ack_o,
   output logic                         m_err_o,
   output logic [DATA_W-1:0]            m_rdata_o,
   output logic [NUM_SLAVES-1:0]        s_sel_o,
   output logic                         s_we_o,
   output logic [ADDR_W-1:0]            s_addr_o,
   output logic [DATA_W-1:0]            s_wdata_o,
   output logic [DATA_W/8-1:0]          s_be_o,
   input  logic [NUM_SLAVES-1:0]        s_ack_i,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
   output logic                         busy_o
`ifdef DBUS_BRIDGE_ERR_CAPTURE_EN
   ,
   output logic [ADDR_W-1:0]            err_addr_o,
   output logic                         err_cause_o,
   output logic [15:0]                  err_cnt_o
`endif
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST =
      TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [NUM_SLAVES-1:0] dec_hit;
   logic                  dec_any;
   logic                  sel_ack;
   logic [DATA_W-1:0]     sel_rdata;
   logic                  unmapped_fire;
   logic                  timeout_fire;

   // Priority decode: scan high to low so the lowest matching index wins.
   always_comb begin
      dec_hit = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((m_addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
             (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
            dec_hit    = '0;
            dec_hit[i] = 1'b1;
         end
      end
   end

   assign dec_any = |dec_hit;

   // s_sel_o is the registered hit vector, so it also gates ack and rdata;
   // acks from non-selected slaves fall out of the AND.
   always_comb begin
      sel_ack   = |(s_ack_i & s_sel_o);
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (s_sel_o[i]) begin
            sel_rdata = sel_rdata | s_rdata_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign unmapped_fire = (state == IDLE) && m_req_i && !dec_any;
   assign timeout_fire  = (state == WAIT) && !sel_ack &&
                          TO_EN && (cnt == CNT_LAST);

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         m_ack_o   <= 1'b0;
         m_err_o   <= 1'b0;
         m_rdata_o <= '0;
         s_sel_o   <= '0;
         s_we_o    <= 1'b0;
         s_addr_o  <= '0;
         s_wdata_o <= '0;
         s_be_o    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               m_ack_o   <= 1'b0;
               m_err_o   <= 1'b0;
               m_rdata_o <= '0;
               cnt       <= '0;
               if (m_req_i) begin
                  s_we_o    <= m_we_i;
                  s_addr_o  <= m_addr_i;
                  s_wdata_o <= m_wdata_i;
                  s_be_o    <= m_be_i;
                  if (dec_any) begin
                     s_sel_o <= dec_hit;
                     state   <= WAIT;
                  end else begin
                     m_ack_o <= 1'b1;
                     m_err_o <= 1'b1;
                     state   <= RESP;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt + CNT_W'(1);
               // Ack is tested first so it beats a same-cycle expiry.
               if (sel_ack) begin
                  m_ack_o   <= 1'b1;
                  m_err_o   <= 1'b0;
                  m_rdata_o <= s_we_o ? '0 : sel_rdata;
                  s_sel_o   <= '0;
                  state     <= RESP;
               end else if (timeout_fire) begin
                  m_ack_o   <= 1'b1;
                  m_err_o   <= 1'b1;
                  m_rdata_o <= '0;
                  s_sel_o   <= '0;
                  state     <= RESP;
               end
            end
            RESP: begin
               m_ack_o   <= 1'b0;
               m_err_o   <= 1'b0;
               m_rdata_o <= '0;
               cnt       <= '0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef DBUS_BRIDGE_ERR_CAPTURE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_addr_o  <= '0;
         err_cause_o <= 1'b0;
         err_cnt_o   <= '0;
      end else if (unmapped_fire || timeout_fire) begin
         // Unmapped fires before capture, so take the live address there.
         err_addr_o  <= unmapped_fire ? m_addr_i : s_addr_o;
         err_cause_o <= timeout_fire;
         if (err_cnt_o != 16'hFFFF) begin
            err_cnt_o <= err_cnt_o + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dbus_periph_bridge.sv
// tb_dbus_periph_bridge: directed self-checking bench for the bridge.
// Three slaves, overlapping 0/2, timeout of 8 cycles.
module tb_dbus_periph_bridge;

   localparam int NS = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;
   localparam logic [NS*AW-1:0] BASE =
      {32'h4000_0000, 32'h9000_0000, 32'h4000_0000};
   localparam logic [NS*AW-1:0] MASK =
      {32'hFF00_0000, 32'hFFFF_0000, 32'hF000_0000};

   logic           clk = 1'b0;
   logic           rst;
   logic           m_req;
   logic           m_we;
   logic [AW-1:0]  m_addr;
   logic [DW-1:0]  m_wdata;
   logic [3:0]     m_be;
   logic           m_ack_o;
   logic           m_err_o;
   logic [DW-1:0]  m_rdata_o;
   logic [NS-1:0]  s_sel_o;
   logic           s_we_o;
   logic [AW-1:0]  s_addr_o;
   logic [DW-1:0]  s_wdata_o;
   logic [3:0]     s_be_o;
   logic [NS-1:0]  s_ack;
   logic [NS*DW-1:0] s_rdata;
   logic           busy_o;
`ifdef DBUS_BRIDGE_ERR_CAPTURE_EN
   logic [AW-1:0]  err_addr_o;
   logic           err_cause_o;
   logic [15:0]    err_cnt_o;
`endif

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   dbus_periph_bridge #(
      .NUM_SLAVES(NS),
      .ADDR_W(AW),
      .DATA_W(DW),
      .SLV_BASE(BASE),
      .SLV_MASK(MASK),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .m_req_i(m_req),
      .m_we_i(m_we),
      .m_addr_i(m_addr),
      .m_wdata_i(m_wdata),
      .m_be_i(m_be),
      .m_ack_o(m_ack_o),
      .m_err_o(m_err_o),
      .m_rdata_o(m_rdata_o),
      .s_sel_o(s_sel_o),
      .s_we_o(s_we_o),
      .s_addr_o(s_addr_o),
      .s_wdata_o(s_wdata_o),
      .s_be_o(s_be_o),
      .s_ack_i(s_ack),
      .s_rdata_i(s_rdata),
      .busy_o(busy_o)
`ifdef DBUS_BRIDGE_ERR_CAPTURE_EN
      ,
      .err_addr_o(err_addr_o),
      .err_cause_o(err_cause_o),
      .err_cnt_o(err_cnt_o)
`endif
   );

   task automatic test_reset();
      rst = 1'b1;
      m_req = 1'b0;
      m_we = 1'b0;
      m_addr = '0;
      m_wdata = '0;
      m_be = '0;
      s_ack = '0;
      s_rdata = '0;
      repeat (2) @(negedge clk);
      total++; if (m_ack_o !== 1'b0) $display("FAIL rst_ack got %b want 0", m_ack_o); else passed++;
      total++; if (m_err_o !== 1'b0) $display("FAIL rst_err got %b want 0", m_err_o); else passed++;
      total++; if (m_rdata_o !== 32'h0) $display("FAIL rst_rdata got %h want 0", m_rdata_o); else passed++;
      total++; if (s_sel_o !== 3'b000) $display("FAIL rst_sel got %b want 000", s_sel_o); else passed++;
      total++; if ({s_we_o, s_addr_o, s_wdata_o, s_be_o} !== 69'h0) $display("FAIL rst_sbus got %h want 0", {s_we_o, s_addr_o, s_wdata_o, s_be_o}); else passed++;
      total++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %b want 0", busy_o); else passed++;
`ifdef DBUS_BRIDGE_ERR_CAPTURE_EN
      total++; if ({err_addr_o, err_cause_o, err_cnt_o} !== 49'h0) $display("FAIL rst_errcap got %h want 0", {err_addr_o, err_cause_o, err_cnt_o}); else passed++;
`endif
      rst = 1'b0;
   endtask

   task automatic test_read();
      @(negedge clk);
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h9000_0010; m_be = 4'hF;
      @(negedge clk);
      total++; if (s_sel_o !== 3'b010) $display("FAIL rd_sel got %b want 010", s_sel_o); else passed++;
      total++; if (busy_o !== 1'b1) $display("FAIL rd_busy got %b want 1", busy_o); else passed++;
      total++; if (m_ack_o !== 1'b0) $display("FAIL rd_early_ack got %b want 0", m_ack_o); else passed++;
      total++; if (s_addr_o !== 32'h9000_0010) $display("FAIL rd_saddr got %h want 90000010", s_addr_o); else passed++;
      s_ack = 3'b010;
      s_rdata = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
      @(negedge clk);
      total++; if (m_ack_o !== 1'b1) $display("FAIL rd_ack got %b want 1", m_ack_o); else passed++;
      total++; if (m_err_o !== 1'b0) $display("FAIL rd_err got %b want 0", m_err_o); else passed++;
      total++; if (m_rdata_o !== 32'hDEAD_BEEF) $display("FAIL rd_rdata got %h want deadbeef", m_rdata_o); else passed++;
      total++; if (s_sel_o !== 3'b000) $display("FAIL rd_sel_clr got %b want 000", s_sel_o); else passed++;
      m_req = 1'b0; s_ack = '0;
      @(negedge clk);
      total++; if ({m_ack_o, m_rdata_o} !== 33'h0) $display("FAIL rd_after got %h want 0", {m_ack_o, m_rdata_o}); else passed++;
      total++; if (busy_o !== 1'b0) $display("FAIL rd_idle got %b want 0", busy_o); else passed++;
   endtask

   task automatic test_write();
      @(negedge clk);
      m_req = 1'b1; m_we = 1'b1; m_addr = 32'h9000_0004;
      m_wdata = 32'h1234_5678; m_be = 4'b0011;
      s_rdata = {32'h0, 32'hFFFF_FFFF, 32'h0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (s_sel_o !== 3'b010) $display("FAIL wr_sel[%0d] got %b want 010", i, s_sel_o); else passed++;
         total++; if ({s_we_o, s_addr_o, s_wdata_o, s_be_o} !== {1'b1, 32'h9000_0004, 32'h1234_5678, 4'b0011}) $display("FAIL wr_sbus[%0d] got %h want %h", i, {s_we_o, s_addr_o, s_wdata_o, s_be_o}, {1'b1, 32'h9000_0004, 32'h1234_5678, 4'b0011}); else passed++;
         total++; if (m_ack_o !== 1'b0) $display("FAIL wr_early_ack[%0d] got %b want 0", i, m_ack_o); else passed++;
         if (i == 4) s_ack = 3'b010;
      end
      @(negedge clk);
      total++; if (m_ack_o !== 1'b1) $display("FAIL wr_ack got %b want 1", m_ack_o); else passed++;
      total++; if (m_err_o !== 1'b0) $display("FAIL wr_err got %b want 0", m_err_o); else passed++;
      total++; if (m_rdata_o !== 32'h0) $display("FAIL wr_rdata got %h want 0", m_rdata_o); else passed++;
      m_req = 1'b0; m_we = 1'b0; s_ack = '0;
      @(negedge clk);
      total++; if ({m_ack_o, busy_o} !== 2'b00) $display("FAIL wr_after got %b want 00", {m_ack_o, busy_o}); else passed++;
   endtask

   task automatic test_unmapped();
      @(negedge clk);
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h7000_0000;
      @(negedge clk);
      total++; if (m_ack_o !== 1'b1) $display("FAIL um_ack got %b want 1", m_ack_o); else passed++;
      total++; if (m_err_o !== 1'b1) $display("FAIL um_err got %b want 1", m_err_o); else passed++;
      total++; if (m_rdata_o !== 32'h0) $display("FAIL um_rdata got %h want 0", m_rdata_o); else passed++;
      total++; if (s_sel_o !== 3'b000) $display("FAIL um_sel got %b want 000", s_sel_o); else passed++;
`ifdef DBUS_BRIDGE_ERR_CAPTURE_EN
      total++; if (err_addr_o !== 32'h7000_0000) $display("FAIL um_erraddr got %h want 70000000", err_addr_o); else passed++;
      total++; if (err_cause_o !== 1'b0) $display("FAIL um_cause got %b want 0", err_cause_o); else passed++;
      total++; if (err_cnt_o !== 16'd1) $display("FAIL um_cnt got %0d want 1", err_cnt_o); else passed++;
`endif
      m_req = 1'b0;
      @(negedge clk);
      total++; if ({m_ack_o, m_err_o, busy_o, s_sel_o} !== 6'b0) $display("FAIL um_after got %b want 000000", {m_ack_o, m_err_o, busy_o, s_sel_o}); else passed++;
   endtask

   task automatic test_timeout();
      @(negedge clk);
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h9000_0020;
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         total++; if ({s_sel_o, m_ack_o} !== 4'b0100) $display("FAIL to_wait[%0d] got %b want 0100", i, {s_sel_o, m_ack_o}); else passed++;
      end
      @(negedge clk);
      total++; if ({m_ack_o, m_err_o} !== 2'b11) $display("FAIL to_ack got %b want 11", {m_ack_o, m_err_o}); else passed++;
      total++; if ({m_rdata_o, s_sel_o} !== 35'h0) $display("FAIL to_rdata_sel got %h want 0", {m_rdata_o, s_sel_o}); else passed++;
`ifdef DBUS_BRIDGE_ERR_CAPTURE_EN
      total++; if ({err_addr_o, err_cause_o, err_cnt_o} !== {32'h9000_0020, 1'b1, 16'd2}) $display("FAIL to_errcap got %h want %h", {err_addr_o, err_cause_o, err_cnt_o}, {32'h9000_0020, 1'b1, 16'd2}); else passed++;
`endif
      m_req = 1'b0;
      @(negedge clk);
      total++; if (m_ack_o !== 1'b0) $display("FAIL to_after got %b want 0", m_ack_o); else passed++;
      s_ack = 3'b010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if ({m_ack_o, busy_o, s_sel_o} !== 5'b0) $display("FAIL to_late[%0d] got %b want 00000", i, {m_ack_o, busy_o, s_sel_o}); else passed++;
      end
      s_ack = '0;
   endtask

   task automatic test_overlap_edge();
      @(negedge clk);
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h4000_0000;
      s_rdata = {32'h2222_2222, 32'h3333_3333, 32'hA5A5_0F0F};
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         total++; if ({s_sel_o, m_ack_o} !== 4'b0010) $display("FAIL ov_wait[%0d] got %b want 0010", i, {s_sel_o, m_ack_o}); else passed++;
         if (i == 2) s_ack = 3'b100;
         else if (i == TO - 1) s_ack = 3'b001;
         else s_ack = 3'b000;
      end
      @(negedge clk);
      total++; if ({m_ack_o, m_err_o} !== 2'b10) $display("FAIL ov_ack got %b want 10", {m_ack_o, m_err_o}); else passed++;
      total++; if (m_rdata_o !== 32'hA5A5_0F0F) $display("FAIL ov_rdata got %h want a5a50f0f", m_rdata_o); else passed++;
      m_req = 1'b0; s_ack = '0;
      @(negedge clk);
      total++; if (m_ack_o !== 1'b0) $display("FAIL ov_after got %b want 0", m_ack_o); else passed++;
   endtask

   task automatic test_rst_mid();
      @(negedge clk);
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h9000_0030;
      @(negedge clk);
      total++; if ({busy_o, s_sel_o} !== 4'b1010) $display("FAIL rm_wait got %b want 1010", {busy_o, s_sel_o}); else passed++;
      rst = 1'b1; m_req = 1'b0;
      @(negedge clk);
      total++; if ({s_sel_o, busy_o, m_ack_o} !== 5'b0) $display("FAIL rm_abort got %b want 00000", {s_sel_o, busy_o, m_ack_o}); else passed++;
`ifdef DBUS_BRIDGE_ERR_CAPTURE_EN
      total++; if (err_cnt_o !== 16'd0) $display("FAIL rm_errcnt got %0d want 0", err_cnt_o); else passed++;
`endif
      rst = 1'b0;
      @(negedge clk);
      total++; if (m_ack_o !== 1'b0) $display("FAIL rm_noack got %b want 0", m_ack_o); else passed++;
      m_req = 1'b1; m_addr = 32'h9000_0040;
      @(negedge clk);
      total++; if (s_sel_o !== 3'b010) $display("FAIL rm_sel got %b want 010", s_sel_o); else passed++;
      s_ack = 3'b010;
      s_rdata = {32'h0, 32'hCAFE_F00D, 32'h0};
      @(negedge clk);
      total++; if ({m_ack_o, m_err_o, m_rdata_o} !== {2'b10, 32'hCAFE_F00D}) $display("FAIL rm_new got %h want %h", {m_ack_o, m_err_o, m_rdata_o}, {2'b10, 32'hCAFE_F00D}); else passed++;
      m_req = 1'b0; s_ack = '0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h9000_0050;
      @(negedge clk);
      s_ack = 3'b010;
      s_rdata = {32'h0, 32'h0BAD_CAFE, 32'h1357_9BDF};
      @(negedge clk);
      total++; if ({m_ack_o, m_rdata_o} !== {1'b1, 32'h0BAD_CAFE}) $display("FAIL bb_first got %h want %h", {m_ack_o, m_rdata_o}, {1'b1, 32'h0BAD_CAFE}); else passed++;
      s_ack = '0; m_addr = 32'h4000_0008;
      @(negedge clk);
      total++; if ({m_ack_o, busy_o, s_sel_o} !== 5'b0) $display("FAIL bb_idle got %b want 00000", {m_ack_o, busy_o, s_sel_o}); else passed++;
      @(negedge clk);
      total++; if (s_sel_o !== 3'b001) $display("FAIL bb_sel got %b want 001", s_sel_o); else passed++;
      total++; if (s_addr_o !== 32'h4000_0008) $display("FAIL bb_saddr got %h want 40000008", s_addr_o); else passed++;
      s_ack = 3'b001;
      @(negedge clk);
      total++; if ({m_ack_o, m_err_o, m_rdata_o} !== {2'b10, 32'h1357_9BDF}) $display("FAIL bb_second got %h want %h", {m_ack_o, m_err_o, m_rdata_o}, {2'b10, 32'h1357_9BDF}); else passed++;
      m_req = 1'b0; s_ack = '0;
      @(negedge clk);
      total++; if ({m_ack_o, busy_o} !== 2'b00) $display("FAIL bb_after got %b want 00", {m_ack_o, busy_o}); else passed++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read();
      test_write();
      test_unmapped();
      test_timeout();
      test_overlap_edge();
      test_rst_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
